// File: rtl/mem_access_unit.sv
// Request/ack bridge between the multicycle MIPS controller and a variable-latency memory; owns IR and MDR.
// Optional MEM_TIMEOUT_EN aborts a WAIT after TIMEOUT ack-less cycles and raises sticky mem_err.
module mem_access_unit #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread,
   input  logic              memwrite,
   input  logic              IR_write,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] mdr,
   output logic [5:0]        opcode,
   output logic [5:0]        opr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              mem_err
`endif
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t            state;
   logic              we_q;
   logic              ir_sel_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              strobe;
   logic              abort;

   assign strobe = memread | memwrite;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          err_q;

   assign abort   = (state == WAIT) && !mem_ack && (cnt == CW'(TIMEOUT));
   assign mem_err = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else if (state != WAIT || mem_ack || abort) begin
         cnt   <= '0;
         if (abort) err_q <= 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // Combinational so the controller advances on the same edge that captures data.
   assign stall = ((state == IDLE) && strobe) ||
                  ((state == WAIT) && !mem_ack && !abort);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         ir_sel_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         instr    <= '0;
         mdr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (strobe) begin
                  addr_q   <= addr;
                  wdata_q  <= wdata;
                  we_q     <= memwrite;
                  ir_sel_q <= IR_write & ~memwrite;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  if (!we_q) begin
                     mdr <= mem_rdata;
                     if (ir_sel_q) instr <= mem_rdata;
                  end
                  state <= IDLE;
               end else if (abort) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_req   = (state == WAIT);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign opcode    = instr[31:26];
   assign opr       = instr[5:0];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; the timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset, memread, memwrite, IR_write, mem_ack;
   logic [31:0] addr, wdata, mem_rdata;
   logic        stall, mem_req, mem_we;
   logic [31:0] instr, mdr, mem_addr, mem_wdata;
   logic [5:0]  opcode, opr;
`ifdef MEM_TIMEOUT_EN
   logic        mem_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
      .IR_write(IR_write), .addr(addr), .wdata(wdata), .stall(stall),
      .instr(instr), .mdr(mdr), .opcode(opcode), .opr(opr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_TIMEOUT_EN
      , .mem_err(mem_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      memread = 0; memwrite = 0; IR_write = 0; mem_ack = 0;
   endtask

   initial begin
      reset = 1; idle_inputs();
      addr = 0; wdata = 0; mem_rdata = 0;
      tick(); tick();
      reset = 0;
      settle();
      chk("rst_req",   {31'd0, mem_req}, 0);
      chk("rst_we",    {31'd0, mem_we},  0);
      chk("rst_stall", {31'd0, stall},   0);
      chk("rst_instr", instr, 0);
      chk("rst_mdr",   mdr, 0);
      chk("rst_opc",   {26'd0, opcode}, 0);
      chk("rst_opr",   {26'd0, opr}, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_wdat",  mem_wdata, 0);

      // Fetch, ack in first WAIT cycle
      memread = 1; IR_write = 1; addr = 32'h40;
      settle();
      chk("f_stall0", {31'd0, stall}, 1);
      chk("f_req0",   {31'd0, mem_req}, 0);
      tick();
      mem_ack = 1; mem_rdata = 32'h2009_0005;
      settle();
      chk("f_req1",   {31'd0, mem_req}, 1);
      chk("f_stall1", {31'd0, stall}, 0);
      chk("f_maddr",  mem_addr, 32'h40);
      chk("f_we",     {31'd0, mem_we}, 0);
      tick();
      idle_inputs();
      settle();
      chk("f_instr", instr, 32'h2009_0005);
      chk("f_mdr",   mdr, 32'h2009_0005);
      chk("f_opc",   {26'd0, opcode}, 32'h08);
      chk("f_opr",   {26'd0, opr}, 32'h05);
      chk("f_idle",  {31'd0, mem_req}, 0);

      // lw with 3 cycles of stall, issued in the first IDLE cycle
      memread = 1; addr = 32'h100;
      settle();
      chk("lw_stall0", {31'd0, stall}, 1);
      tick();
      chk("lw_stall1", {31'd0, stall}, 1);
      tick();
      chk("lw_stall2", {31'd0, stall}, 1);
      tick();
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      settle();
      chk("lw_stall3", {31'd0, stall}, 0);
      tick();
      idle_inputs();
      settle();
      chk("lw_mdr",   mdr, 32'hDEAD_BEEF);
      chk("lw_instr", instr, 32'h2009_0005);

      // sw, addr changes mid-transaction
      memwrite = 1; addr = 32'h104; wdata = 32'h1234_5678;
      settle();
      chk("sw_stall0", {31'd0, stall}, 1);
      tick();
      addr = 32'h999; wdata = 32'h0;
      settle();
      chk("sw_we1",   {31'd0, mem_we}, 1);
      chk("sw_addr1", mem_addr, 32'h104);
      chk("sw_wd1",   mem_wdata, 32'h1234_5678);
      chk("sw_stall1", {31'd0, stall}, 1);
      tick();
      mem_ack = 1; mem_rdata = 32'hAAAA_AAAA;
      settle();
      chk("sw_we2",   {31'd0, mem_we}, 1);
      chk("sw_addr2", mem_addr, 32'h104);
      chk("sw_stall2", {31'd0, stall}, 0);
      tick();
      idle_inputs();
      settle();
      chk("sw_mdr",   mdr, 32'hDEAD_BEEF);
      chk("sw_instr", instr, 32'h2009_0005);

      // read+write+IR_write together: write wins
      memread = 1; memwrite = 1; IR_write = 1; addr = 32'h200; wdata = 32'hCAFE_F00D;
      tick();
      chk("rw_we",  {31'd0, mem_we}, 1);
      chk("rw_req", {31'd0, mem_req}, 1);
      mem_ack = 1; mem_rdata = 32'h5555_5555;
      tick();
      idle_inputs();
      settle();
      chk("rw_mdr",   mdr, 32'hDEAD_BEEF);
      chk("rw_instr", instr, 32'h2009_0005);

      // reset in the second WAIT cycle
      memread = 1; IR_write = 1; addr = 32'h300;
      tick();
      tick();
      reset = 1;
      tick();
      reset = 0; idle_inputs();
      settle();
      chk("mr_req",   {31'd0, mem_req}, 0);
      chk("mr_instr", instr, 0);
      chk("mr_mdr",   mdr, 0);
      chk("mr_maddr", mem_addr, 0);
      chk("mr_stall", {31'd0, stall}, 0);
      mem_ack = 1; mem_rdata = 32'h7777_7777;
      tick();
      mem_ack = 0;
      settle();
      chk("stray_mdr",   mdr, 0);
      chk("stray_instr", instr, 0);
      chk("stray_req",   {31'd0, mem_req}, 0);

`ifdef MEM_TIMEOUT_EN
      chk("to_err0", {31'd0, mem_err}, 0);
      memread = 1; IR_write = 1; addr = 32'h40;
      tick();
      mem_ack = 1; mem_rdata = 32'h0C00_0003;
      tick();
      idle_inputs();
      settle();
      chk("to_instr0", instr, 32'h0C00_0003);
      memread = 1; IR_write = 1; addr = 32'h80;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_stall_w%0d", i + 1), {31'd0, stall}, 1);
         tick();
      end
      chk("to_stall_drop", {31'd0, stall}, 0);
      tick();
      idle_inputs();
      settle();
      chk("to_err1", {31'd0, mem_err}, 1);
      chk("to_req",  {31'd0, mem_req}, 0);
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 0;
      tick();
      chk("to_err2",  {31'd0, mem_err}, 1);
      chk("to_instr", instr, 32'h0C00_0003);
      chk("to_mdr",   mdr, 32'h0C00_0003);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
